// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART tx serializer among N_REQ byte sources.
// Optional packet lock (multi-byte packets never interleave): define UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int BUSY_WAIT  = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_send,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     tx_active
);

  localparam int GID_W   = $clog2(N_REQ);
  localparam int CNT_MAX = (BUSY_WAIT > GAP_CYCLES) ? BUSY_WAIT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam state_t DONE_ST = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [N_REQ-1:0]   req_ready_q, req_ready_d;
  logic               tx_send_q, tx_send_d;
  logic               tx_active_q, tx_active_d;
  logic [GID_W:0]     pick;
  logic               locked;

  // First valid index at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [GID_W:0] rr_pick(input logic [N_REQ-1:0] vld,
                                              input logic [GID_W-1:0] ptr);
    logic [GID_W:0]   res;
    logic [GID_W-1:0] cand;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = GID_W'((int'(ptr) + k) % N_REQ);
      if (vld[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] g);
    return (g == GID_W'(N_REQ - 1)) ? '0 : g + GID_W'(1);
  endfunction

  function automatic logic [7:0] byte_sel(input logic [8*N_REQ-1:0] d,
                                          input logic [GID_W-1:0] g);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g == GID_W'(i)) b = d[8*i +: 8];
    end
    return b;
  endfunction

`ifdef UART_ARB_PKT_LOCK_EN
  logic lock_q, lock_d;

  assign locked = lock_q;

  // Lock follows the last flag of the byte actually granted.
  always_comb begin
    lock_d = lock_q;
    if (state_q == IDLE && pick[GID_W]) lock_d = ~req_last[pick[GID_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign locked      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    req_ready_d = '0;
    tx_send_d   = 1'b0;
    pick        = locked ? {req_valid[grant_id_q], grant_id_q} : rr_pick(req_valid, rr_ptr_q);

    case (state_q)
      IDLE: begin
        if (pick[GID_W]) begin
          grant_id_d  = pick[GID_W-1:0];
          tx_data_d   = byte_sel(req_data, pick[GID_W-1:0]);
          req_ready_d = N_REQ'(1) << pick[GID_W-1:0];
          tx_send_d   = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!locked) rr_ptr_d = next_ptr(grant_id_q);
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A send that never raises busy was dropped by tx; release after BUSY_WAIT cycles.
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = DONE_ST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = DONE_ST;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    tx_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      tx_data_q   <= '0;
      req_ready_q <= '0;
      tx_send_q   <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      tx_data_q   <= tx_data_d;
      req_ready_q <= req_ready_d;
      tx_send_q   <= tx_send_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign tx_active = tx_active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, BUSY_WAIT=4, GAP_CYCLES=0) with a simple tx busy model.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           tx_active;

  uart_tx_arbiter #(.N_REQ(N), .BUSY_WAIT(4), .GAP_CYCLES(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .tx_active (tx_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // tx serializer model: busy for busy_len cycles starting the cycle after a send
  int   busy_len = 10;
  logic model_en = 1'b1;
  int   busy_cnt = 0;
  always @(posedge clk) begin
    if (rst)                      busy_cnt <= 0;
    else if (model_en && tx_send) busy_cnt <= busy_len;
    else if (busy_cnt > 0)        busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt > 0);

  // requesters: per-source byte queues, popped on req_ready
  logic [8:0] rq_mem [N][16];
  int         rq_head [N];
  int         rq_tail [N];

  always begin
    @(negedge clk);
    #3;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) rq_head[i] = rq_head[i] + 1;
      if (rq_head[i] < rq_tail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]        = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic last);
    rq_mem[r][rq_tail[r]] = {last, d};
    rq_tail[r] = rq_tail[r] + 1;
  endtask

  // monitor: log every send and check each acknowledge pairs with its send
  int         n_send = 0;
  int         send_cyc [64];
  logic [7:0] send_data [64];
  int         send_gid [64];
  int         send_lastbusy [64];
  int         last_busy = -100;
  int         last_fall = -100;
  logic       act_prev  = 1'b0;
  int         ack_cnt [N];

  always @(negedge clk) begin
    if (tx_busy) last_busy = cyc;
    if (act_prev && !tx_active) last_fall = cyc;
    act_prev = tx_active;
    for (int i = 0; i < N; i++) if (req_ready[i]) ack_cnt[i] = ack_cnt[i] + 1;
    if (tx_send || req_ready != '0)
      chk("ack_pair", 32'({tx_send, req_ready}), 32'(5'b10000 | (5'b00001 << grant_id)));
    if (tx_send && n_send < 64) begin
      send_cyc[n_send]      = cyc;
      send_data[n_send]     = tx_data;
      send_gid[n_send]      = int'(grant_id);
      send_lastbusy[n_send] = last_busy;
      n_send = n_send + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  function automatic logic queues_empty();
    for (int i = 0; i < N; i++) if (rq_head[i] != rq_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_sends(input int target, input int budget);
    int k = 0;
    while (n_send < target && k < budget) begin
      tick(1);
      k++;
    end
    if (n_send < target) chk("wait_send_timeout", 32'(n_send), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(queues_empty() && !tx_active && !tx_busy) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) chk("wait_idle_timeout", 32'(tx_active), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_ready"},  32'(req_ready), 32'(0));
    chk({pfx, "_send"},   32'(tx_send),   32'(0));
    chk({pfx, "_data"},   32'(tx_data),   32'(0));
    chk({pfx, "_gid"},    32'(grant_id),  32'(0));
    chk({pfx, "_active"}, 32'(tx_active), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, sends=%0d", n_send);
    $fatal(1);
  end

  initial begin
    int b;
    int p;
    int a0 [N];
    logic [7:0] exp_d [4];
    int         exp_g [4];

    // reset state
    rst = 1'b1;
    tick(3);
    chk_zero_outputs("rst");
    rst = 1'b0;
    tick(2);

    // single byte from requester 0, busy for 10 cycles
    b = n_send;
    busy_len = 10;
    p = cyc;
    push(0, 8'hA5, 1'b1);
    wait_sends(b + 1, 20);
    wait_idle(60);
    chk("t1_count",   32'(n_send - b), 32'(1));
    chk("t1_data",    32'(send_data[b]), 32'hA5);
    chk("t1_gid",     32'(send_gid[b]), 32'(0));
    chk("t1_latency", 32'(send_cyc[b] - p), 32'(1));
    chk("t1_busy",    32'(last_busy - send_cyc[b]), 32'(10));
    chk("t1_fall",    32'(last_fall - send_cyc[b]), 32'(12));
    chk("t1_hold",    32'(tx_data), 32'hA5);
    chk("t1_ack0",    32'(ack_cnt[0]), 32'(1));

    // requesters 0 and 2 together from rr_ptr=0
    do_reset();
    b = n_send;
    push(0, 8'h11, 1'b1);
    push(2, 8'h33, 1'b1);
    wait_sends(b + 2, 60);
    wait_idle(60);
    chk("t2_data0",  32'(send_data[b]), 32'h11);
    chk("t2_gid0",   32'(send_gid[b]), 32'(0));
    chk("t2_data1",  32'(send_data[b+1]), 32'h33);
    chk("t2_gid1",   32'(send_gid[b+1]), 32'(2));
    chk("t2_space",  32'(send_cyc[b+1] - send_cyc[b]), 32'(13));
    chk("t2_after_busy", 32'(send_cyc[b+1] - send_lastbusy[b+1]), 32'(3));

    // all four requesters continuously valid, two bytes each
    do_reset();
    busy_len = 2;
    b = n_send;
    for (int i = 0; i < N; i++) a0[i] = ack_cnt[i];
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 8'(16 * (i + 1) + k), 1'b1);
    wait_sends(b + 8, 200);
    wait_idle(60);
    for (int j = 0; j < 8; j++) begin
      chk("t3_gid",  32'(send_gid[b+j]), 32'(j % 4));
      chk("t3_data", 32'(send_data[b+j]), 32'(16 * (j % 4 + 1) + j / 4));
    end
    chk("t3_space", 32'(send_cyc[b+1] - send_cyc[b]), 32'(5));
    for (int i = 0; i < N; i++) chk("t3_acks", 32'(ack_cnt[i] - a0[i]), 32'(2));

    // tx never raises busy: timeout releases the arbiter
    do_reset();
    model_en = 1'b0;
    b = n_send;
    push(1, 8'h5A, 1'b1);
    push(3, 8'hC3, 1'b1);
    wait_sends(b + 2, 40);
    chk("t4_fall",  32'(last_fall - send_cyc[b]), 32'(5));
    chk("t4_data0", 32'(send_data[b]), 32'h5A);
    chk("t4_gid0",  32'(send_gid[b]), 32'(1));
    chk("t4_data1", 32'(send_data[b+1]), 32'hC3);
    chk("t4_gid1",  32'(send_gid[b+1]), 32'(3));
    chk("t4_space", 32'(send_cyc[b+1] - send_cyc[b]), 32'(6));
    wait_idle(60);
    model_en = 1'b1;

    // reset pulsed in WAIT_DONE; pending requester 1 served afterwards
    do_reset();
    busy_len = 10;
    b = n_send;
    for (int i = 0; i < N; i++) a0[i] = ack_cnt[i];
    push(0, 8'h77, 1'b1);
    push(1, 8'h99, 1'b1);
    wait_sends(b + 1, 20);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk_zero_outputs("t5_rst");
    p = cyc;
    rst = 1'b0;
    wait_sends(b + 2, 20);
    chk("t5_data",    32'(send_data[b+1]), 32'h99);
    chk("t5_gid",     32'(send_gid[b+1]), 32'(1));
    chk("t5_latency", 32'(send_cyc[b+1] - p), 32'(1));
    wait_idle(60);
    chk("t5_count",   32'(n_send - b), 32'(2));
    chk("t5_ack0",    32'(ack_cnt[0] - a0[0]), 32'(1));

    // three-byte packet from requester 1 while requester 0 waits
    do_reset();
    busy_len = 3;
    b = n_send;
    push(1, 8'hB1, 1'b0);
    wait_sends(b + 1, 20);
    push(0, 8'h0F, 1'b1);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    wait_sends(b + 4, 100);
    wait_idle(60);
`ifdef UART_ARB_PKT_LOCK_EN
    exp_d = '{8'hB1, 8'hB2, 8'hB3, 8'h0F};
    exp_g = '{1, 1, 1, 0};
`else
    exp_d = '{8'hB1, 8'h0F, 8'hB2, 8'hB3};
    exp_g = '{1, 0, 1, 1};
`endif
    for (int j = 0; j < 4; j++) begin
      chk("t6_data", 32'(send_data[b+j]), 32'(exp_d[j]));
      chk("t6_gid",  32'(send_gid[b+j]), 32'(exp_g[j]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
